// File: rtl/regfile_write_queue_pkg.sv
// regfile_write_queue_pkg: shared widths, pointer width and entry type for the write queue
package regfile_write_queue_pkg;
  localparam int WQ_DEPTH = 4;
  localparam int WQ_ADDR_W = 2;
  localparam int WQ_DATA_W = 4;
  localparam int WQ_PTR_W = $clog2(WQ_DEPTH);
  typedef struct packed {
    logic [WQ_ADDR_W-1:0] addr;
    logic [WQ_DATA_W-1:0] data;
  } wq_entry_t;
endpackage

// File: rtl/regfile_write_queue_if.sv
// regfile_write_queue_if: valid/ready write-request channel from execution units into the queue
interface regfile_write_queue_if
  import regfile_write_queue_pkg::*;
#(
  parameter int ADDR_W = WQ_ADDR_W,
  parameter int DATA_W = WQ_DATA_W
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  modport master (output valid, addr, data, input ready);
  modport slave (input valid, addr, data, output ready);
endinterface

// File: rtl/wq_match.sv
// wq_match: DEPTH-way pending-address compare; with REGFILE_WRITE_QUEUE_FWD_EN also picks the youngest matching data
module wq_match
  import regfile_write_queue_pkg::*;
#(
  parameter int DEPTH = WQ_DEPTH,
  parameter int ADDR_W = WQ_ADDR_W,
`ifdef REGFILE_WRITE_QUEUE_FWD_EN
  parameter int DATA_W = WQ_DATA_W,
`endif
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] ent_addr [DEPTH],
`ifdef REGFILE_WRITE_QUEUE_FWD_EN
  input  logic [DATA_W-1:0] ent_data [DEPTH],
  output logic [DATA_W-1:0] data,
`endif
  input  logic [DEPTH-1:0]  occ,
  input  logic [PTR_W-1:0]  head,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              hit
);
  logic [PTR_W-1:0] idx;
  // Walk oldest to youngest so the last match seen is the youngest
  always_comb begin
    hit = 1'b0;
    idx = head;
`ifdef REGFILE_WRITE_QUEUE_FWD_EN
    data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (occ[idx] && ent_addr[idx] == lk_addr) begin
        hit = 1'b1;
`ifdef REGFILE_WRITE_QUEUE_FWD_EN
        data = ent_data[idx];
`endif
      end
    end
  end
endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: FIFO of pending regfile writes draining one per cycle, with pending-address lookup.
// Define REGFILE_WRITE_QUEUE_FWD_EN to add lk_data forwarding of the youngest matching entry.
module regfile_write_queue
  import regfile_write_queue_pkg::*;
#(
  parameter int DEPTH = WQ_DEPTH,
  parameter int ADDR_W = WQ_ADDR_W,
  parameter int DATA_W = WQ_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              ASYNCRESETN,
  regfile_write_queue_if.slave in_if,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
`ifdef REGFILE_WRITE_QUEUE_FWD_EN
  output logic [DATA_W-1:0] lk_data,
`endif
  output logic [CNT_W-1:0]  count
);
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  age [DEPTH];
  logic [DEPTH-1:0]  occ;
  logic              push, pop;
  // ready depends only on registered count, never on wr_stall
  assign in_if.ready = count_q != CNT_W'(DEPTH);
  assign push = in_if.valid && in_if.ready;
  assign wr_en = count_q != '0 && !wr_stall;
  assign pop = wr_en;
  assign wr_addr = addr_q[head_q];
  assign wr_data = data_q[head_q];
  assign count = count_q;
  always_comb begin
    head_d = pop ? head_q + PTR_W'(1) : head_q;
    tail_d = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    addr_d = addr_q;
    data_d = data_q;
    if (push) begin
      addr_d[tail_q] = in_if.addr;
      data_d[tail_q] = in_if.data;
    end
  end
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      addr_q <= '{default: '0};
      data_q <= '{default: '0};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  // A slot is live when its distance from head is below the occupancy count
  genvar i;
  for (i = 0; i < DEPTH; i++) begin : g_occ
    assign age[i] = PTR_W'(i) - head_q;
    assign occ[i] = count_q > CNT_W'(age[i]);
  end
  wq_match #(
    .DEPTH(DEPTH),
`ifdef REGFILE_WRITE_QUEUE_FWD_EN
    .DATA_W(DATA_W),
`endif
    .ADDR_W(ADDR_W)
  ) u_match (
    .ent_addr(addr_q),
`ifdef REGFILE_WRITE_QUEUE_FWD_EN
    .ent_data(data_q),
    .data(lk_data),
`endif
    .occ(occ),
    .head(head_q),
    .lk_addr(lk_addr),
    .hit(lk_hit)
  );
endmodule
